// File: rtl/guard_prng_if.sv
// guard_prng_if: seed and guard-word handshake bundle between seed source, PRNG and masked multiplier
interface guard_prng_if;
  logic        seed_valid;
  logic [31:0] seed;
  logic        seed_ready;
  logic        guards_valid;
  logic        guards_ready;
  logic [3:0]  guards;
  logic        seed_err;
  logic        reseed_req;
  modport master (
    output seed_valid, seed, guards_ready,
    input  seed_ready, guards_valid, guards, seed_err, reseed_req
  );
  modport slave (
    input  seed_valid, seed, guards_ready,
    output seed_ready, guards_valid, guards, seed_err, reseed_req
  );
endinterface

// File: rtl/guard_prng.sv
// guard_prng: seeded 32-bit LFSR delivering 4-bit guard words with warm-up and reseed limit
module guard_prng #(
  parameter int          WARMUP_CYCLES = 8,
  parameter logic [15:0] RESEED_LIMIT  = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  guard_prng_if.slave bus
);
  localparam int WW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {UNSEEDED, WARMUP, RUN, STALE} state_t;
  state_t        state_q;
  logic [31:0]   s_q;
  logic [31:0]   adv_d;
  logic [WW-1:0] wcnt_q;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic          seed_err_q;
  // four LFSR steps per advance, and saturating next word count
  always_comb begin
    adv_d = s_q;
    for (int i = 0; i < 4; i++) adv_d = {adv_d[30:0], adv_d[31] ^ adv_d[21] ^ adv_d[1] ^ adv_d[0]};
    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end
  // FSM: a nonzero seed wins over everything, a zero seed only flags an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNSEEDED;
      s_q        <= '0;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
    end else if (bus.seed_valid && bus.seed != 32'd0) begin
      s_q        <= bus.seed;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
      state_q    <= (WARMUP_CYCLES == 0) ? RUN : WARMUP;
    end else begin
      if (bus.seed_valid) seed_err_q <= 1'b1;
      case (state_q)
        WARMUP: begin
          s_q    <= adv_d;
          wcnt_q <= wcnt_q + WW'(1);
          if (wcnt_q == WW'(WARMUP_CYCLES - 1)) state_q <= RUN;
        end
        RUN: if (bus.guards_ready) begin
          s_q   <= adv_d;
          cnt_q <= cnt_d;
          if (cnt_d == RESEED_LIMIT) state_q <= STALE;
        end
        default: ;
      endcase
    end
  end
  assign bus.seed_ready   = 1'b1;
  assign bus.guards_valid = (state_q == RUN);
  assign bus.guards       = (state_q == RUN) ? s_q[3:0] : 4'h0;
  assign bus.seed_err     = seed_err_q;
  assign bus.reseed_req   = (state_q == STALE);
endmodule

// File: tb/tb_guard_prng.sv
// tb_guard_prng: directed vector table plus hand sequences for warm-up, stall, priority and async reset
module tb_guard_prng;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  guard_prng_if a_if();
  guard_prng_if b_if();
  guard_prng #(.WARMUP_CYCLES(8), .RESEED_LIMIT(16'hFFFF)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  guard_prng #(.WARMUP_CYCLES(0), .RESEED_LIMIT(16'd3))    dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  typedef struct {
    logic        sv;
    logic [31:0] seed;
    logic        gr;
    logic        v;
    logic [3:0]  g;
    logic        err;
    logic        rs;
  } vec_t;
  vec_t tbl [14];
  function automatic logic [31:0] adv(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < 4; i++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [31:0] exp;
  initial begin
    tbl[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 32'h1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'h1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    a_if.seed_valid = 1'b0; a_if.seed = '0; a_if.guards_ready = 1'b0;
    b_if.seed_valid = 1'b0; b_if.seed = '0; b_if.guards_ready = 1'b0;
    #12;
    chk("rst_a_valid", 32'(a_if.guards_valid), 0);
    chk("rst_a_guards", 32'(a_if.guards), 0);
    chk("rst_a_err", 32'(a_if.seed_err), 0);
    chk("rst_a_reseed", 32'(a_if.reseed_req), 0);
    chk("rst_a_ready", 32'(a_if.seed_ready), 1);
    chk("rst_b_valid", 32'(b_if.guards_valid), 0);
    chk("rst_b_ready", 32'(b_if.seed_ready), 1);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      b_if.seed_valid = tbl[i].sv;
      b_if.seed = tbl[i].seed;
      b_if.guards_ready = tbl[i].gr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(b_if.guards_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_guards", i), 32'(b_if.guards), 32'(tbl[i].g));
      chk($sformatf("vec%0d_err", i), 32'(b_if.seed_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_reseed", i), 32'(b_if.reseed_req), 32'(tbl[i].rs));
    end
    b_if.seed_valid = 1'b0; b_if.guards_ready = 1'b0;
    a_if.seed_valid = 1'b1; a_if.seed = 32'h0;
    step();
    chk("zero_seed_err", 32'(a_if.seed_err), 1);
    chk("zero_seed_valid", 32'(a_if.guards_valid), 0);
    a_if.seed = 32'h1;
    step();
    a_if.seed_valid = 1'b0;
    chk("seed1_err", 32'(a_if.seed_err), 0);
    chk("warm_valid0", 32'(a_if.guards_valid), 0);
    exp = 32'h1;
    repeat (8) exp = adv(exp);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("warm_valid%0d", k), 32'(a_if.guards_valid), 0);
    end
    step();
    chk("warm_done_valid", 32'(a_if.guards_valid), 1);
    chk("warm_done_guards", 32'(a_if.guards), 32'(exp[3:0]));
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d_guards", k), 32'(a_if.guards), 32'(exp[3:0]));
      chk($sformatf("stall%0d_valid", k), 32'(a_if.guards_valid), 1);
    end
    a_if.guards_ready = 1'b1;
    step();
    exp = adv(exp);
    chk("take_guards", 32'(a_if.guards), 32'(exp[3:0]));
    a_if.seed_valid = 1'b1; a_if.seed = 32'hDEADBEEF;
    step();
    a_if.seed_valid = 1'b0; a_if.guards_ready = 1'b0;
    chk("prio_valid", 32'(a_if.guards_valid), 0);
    chk("prio_guards", 32'(a_if.guards), 0);
    exp = 32'hDEADBEEF;
    repeat (8) exp = adv(exp);
    repeat (7) step();
    chk("prio_warm_valid", 32'(a_if.guards_valid), 0);
    step();
    chk("prio_run_valid", 32'(a_if.guards_valid), 1);
    chk("prio_run_guards", 32'(a_if.guards), 32'(exp[3:0]));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_if.guards_valid), 0);
    chk("arst_guards", 32'(a_if.guards), 0);
    chk("arst_b_reseed", 32'(b_if.reseed_req), 0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("post_rst%0d_valid", k), 32'(a_if.guards_valid), 0);
    end
    a_if.seed_valid = 1'b1; a_if.seed = 32'h1;
    step();
    a_if.seed_valid = 1'b0;
    exp = 32'h1;
    repeat (8) exp = adv(exp);
    repeat (7) step();
    chk("reseed_warm_valid", 32'(a_if.guards_valid), 0);
    step();
    chk("reseed_run_valid", 32'(a_if.guards_valid), 1);
    chk("reseed_run_guards", 32'(a_if.guards), 32'(exp[3:0]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
